cbfp_norm_stream_param: RTL and testbench

//  Parametrised streaming CBFP final normaliser for the FFT output path.
//  - Each beat carries LANES complex samples plus two per-component block exponents (index1, index2).
//  - Every component is rescaled by (REF_SUM - index1 - index2) with rounding, then saturated to OUT_W.
//  - Adds ready/valid backpressure, block framing (sop/eop) and a per-block saturation count.

---
 rtl/cbfp_pkg.sv | 59 +++++
 rtl/cbfp_lane_scaler.sv | 28 ++
 rtl/cbfp_norm_stream_param.sv | 197 +++++++++++++++++++
 tb/tb_cbfp_norm_stream_param.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared definitions for the CBFP output normaliser: the arithmetic word
// type and the per-component shift/round/saturate helper.
package cbfp_pkg;

    // Working width for one component before saturation. It is wide enough
    // for IN_W + OUT_W + 1 with any supported widths.
    localparam int CALC_W    = 32;
    localparam int IDX_W_DEF = 5;
    // Width of a signed shift amount built from two IDX_W_DEF-bit indices.
    localparam int SH_W      = IDX_W_DEF + 3;

    typedef logic signed [CALC_W-1:0] calc_t;

    // Result of one normalisation: saturated value plus the clip flag.
    typedef struct packed {
        logic  sat;
        calc_t y;
    } srs_t;

    // Shift x by sh. Positive sh is a rounding right shift (half up).
    // Negative sh is a left shift. The result is then clipped to a signed
    // out_w-bit range. Right shifts are clamped to in_w, because every
    // in_w-bit value has already rounded to 0 at that point. Left shifts are
    // clamped to out_w, because any nonzero value already clips there.
    function automatic srs_t sat_round_shift(input calc_t x, input calc_t sh,
                                             input int in_w, input int out_w);
        logic signed [2*CALC_W-1:0] wide_x;
        logic signed [2*CALC_W-1:0] acc;
        logic signed [2*CALC_W-1:0] hi_v;
        logic signed [2*CALC_W-1:0] lo_v;
        int   s;
        srs_t r;
        wide_x = {{CALC_W{x[CALC_W-1]}}, x};
        hi_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo_v   = -(64'sd1 <<< (out_w - 1));
        if (sh > 32'sd0) begin
            s   = (sh > in_w) ? in_w : int'(sh);
            acc = (wide_x + (64'sd1 <<< (s - 1))) >>> s;
        end else if (sh == 32'sd0) begin
            s   = 0;
            acc = wide_x;
        end else begin
            s   = (-sh > out_w) ? out_w : int'(-sh);
            acc = wide_x <<< s;
        end
        if (acc > hi_v) begin
            r.y   = hi_v[CALC_W-1:0];
            r.sat = 1'b1;
        end else if (acc < lo_v) begin
            r.y   = lo_v[CALC_W-1:0];
            r.sat = 1'b1;
        end else begin
            r.y   = acc[CALC_W-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cbfp_lane_scaler.sv
// Combinational normaliser for one signed component: rounding shift by a
// signed amount, followed by saturation to OUT_W bits.
module cbfp_lane_scaler #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 13,
    parameter int SH_BITS = 8
) (
    input  logic [IN_W-1:0]    i_x,
    input  logic [SH_BITS-1:0] i_sh,
    output logic [OUT_W-1:0]   o_y,
    output logic               o_sat
);
    import cbfp_pkg::*;

    calc_t w_x;
    calc_t w_sh;
    srs_t  w_res;
    logic  w_unused_hi;

    assign w_x         = {{(CALC_W-IN_W){i_x[IN_W-1]}}, i_x};
    assign w_sh        = {{(CALC_W-SH_BITS){i_sh[SH_BITS-1]}}, i_sh};
    assign w_res       = sat_round_shift(w_x, w_sh, IN_W, OUT_W);
    assign o_y         = w_res.y[OUT_W-1:0];
    assign o_sat       = w_res.sat;
    // Bits above OUT_W are pure sign copies after saturation.
    assign w_unused_hi = ^w_res.y[CALC_W-1:OUT_W];

endmodule

// File: rtl/cbfp_norm_stream_param.sv
// Streaming CBFP final normaliser. It has two register stages with
// ready/valid backpressure. S1 captures data and the per-component shift.
// S2 captures the rescaled, saturated result, the block framing and the
// per-block saturation count.
module cbfp_norm_stream_param #(
    parameter  int LANES     = 16,
    parameter  int BLOCK_LEN = 512,
    parameter  int IN_W      = 16,
    parameter  int OUT_W     = 13,
    parameter  int IDX_W     = 5,
    parameter  int REF_SUM   = 23,
    localparam int CNT_W     = $clog2(2*BLOCK_LEN+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES*IN_W-1:0]  i_in_re,
    input  logic [LANES*IN_W-1:0]  i_in_im,
    input  logic [LANES*IDX_W-1:0] i_idx1_re,
    input  logic [LANES*IDX_W-1:0] i_idx1_im,
    input  logic [LANES*IDX_W-1:0] i_idx2_re,
    input  logic [LANES*IDX_W-1:0] i_idx2_im,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*OUT_W-1:0] o_out_re,
    output logic [LANES*OUT_W-1:0] o_out_im,
    output logic                   o_out_sop,
    output logic                   o_out_eop,
    output logic [CNT_W-1:0]       o_sat_cnt
);
    import cbfp_pkg::*;

    localparam int BEATS   = BLOCK_LEN / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SH_BITS = IDX_W + 3;

    logic                     r_s1_valid;
    logic [LANES*IN_W-1:0]    r_s1_re;
    logic [LANES*IN_W-1:0]    r_s1_im;
    logic [LANES*SH_BITS-1:0] r_s1_sh_re;
    logic [LANES*SH_BITS-1:0] r_s1_sh_im;
    logic                     r_s1_sop;
    logic                     r_s1_eop;
    logic [BEAT_W-1:0]        r_beat;
    logic [CNT_W-1:0]         r_sat_acc;

    logic                     r_out_valid;
    logic [LANES*OUT_W-1:0]   r_out_re;
    logic [LANES*OUT_W-1:0]   r_out_im;
    logic                     r_out_sop;
    logic                     r_out_eop;
    logic [CNT_W-1:0]         r_sat_cnt;

    logic                     w_s2_adv;
    logic                     w_s1_adv;
    logic                     w_accept;
    logic                     w_beat_first;
    logic                     w_beat_last;
    logic [LANES*SH_BITS-1:0] w_sh_re;
    logic [LANES*SH_BITS-1:0] w_sh_im;
    logic [LANES*OUT_W-1:0]   w_y_re;
    logic [LANES*OUT_W-1:0]   w_y_im;
    logic [LANES-1:0]         w_sat_re;
    logic [LANES-1:0]         w_sat_im;
    logic [CNT_W-1:0]         w_beat_sat;

    assign w_s2_adv     = !r_out_valid || i_out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign w_accept     = i_in_valid && w_s1_adv;
    assign w_beat_first = (r_beat == {BEAT_W{1'b0}});
    assign w_beat_last  = (r_beat == BEAT_W'(BEATS - 1));

    assign o_in_ready   = w_s1_adv;
    assign o_out_valid  = r_out_valid;
    assign o_out_re     = r_out_re;
    assign o_out_im     = r_out_im;
    assign o_out_sop    = r_out_sop;
    assign o_out_eop    = r_out_eop;
    assign o_sat_cnt    = r_sat_cnt;

    // Per-component shift amount: REF_SUM minus the sum of both indices.
    always_comb begin
        w_sh_re = {(LANES*SH_BITS){1'b0}};
        w_sh_im = {(LANES*SH_BITS){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_sh_re[i*SH_BITS +: SH_BITS] = SH_BITS'(REF_SUM)
                - SH_BITS'({1'b0, i_idx1_re[i*IDX_W +: IDX_W]} + {1'b0, i_idx2_re[i*IDX_W +: IDX_W]});
            w_sh_im[i*SH_BITS +: SH_BITS] = SH_BITS'(REF_SUM)
                - SH_BITS'({1'b0, i_idx1_im[i*IDX_W +: IDX_W]} + {1'b0, i_idx2_im[i*IDX_W +: IDX_W]});
        end
    end

    // Stage 1 capture and beat counter. Flush wins over any accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_re    <= {(LANES*IN_W){1'b0}};
            r_s1_im    <= {(LANES*IN_W){1'b0}};
            r_s1_sh_re <= {(LANES*SH_BITS){1'b0}};
            r_s1_sh_im <= {(LANES*SH_BITS){1'b0}};
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_beat     <= {BEAT_W{1'b0}};
        end else if (i_flush) begin
            r_s1_valid <= 1'b0;
            r_s1_re    <= {(LANES*IN_W){1'b0}};
            r_s1_im    <= {(LANES*IN_W){1'b0}};
            r_s1_sh_re <= {(LANES*SH_BITS){1'b0}};
            r_s1_sh_im <= {(LANES*SH_BITS){1'b0}};
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_beat     <= {BEAT_W{1'b0}};
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_re    <= i_in_re;
                r_s1_im    <= i_in_im;
                r_s1_sh_re <= w_sh_re;
                r_s1_sh_im <= w_sh_im;
                r_s1_sop   <= w_beat_first;
                r_s1_eop   <= w_beat_last;
                r_beat     <= w_beat_last ? {BEAT_W{1'b0}} : r_beat + BEAT_W'(1);
            end
        end
    end

    // One scaler per component, working on the stage-1 registers.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cbfp_lane_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_BITS(SH_BITS)) u_re (
            .i_x   (r_s1_re[g*IN_W +: IN_W]),
            .i_sh  (r_s1_sh_re[g*SH_BITS +: SH_BITS]),
            .o_y   (w_y_re[g*OUT_W +: OUT_W]),
            .o_sat (w_sat_re[g])
        );
        cbfp_lane_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_BITS(SH_BITS)) u_im (
            .i_x   (r_s1_im[g*IN_W +: IN_W]),
            .i_sh  (r_s1_sh_im[g*SH_BITS +: SH_BITS]),
            .o_y   (w_y_im[g*OUT_W +: OUT_W]),
            .o_sat (w_sat_im[g])
        );
    end

    // Count clipped components in the beat that currently sits in stage 1.
    always_comb begin
        w_beat_sat = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_beat_sat = w_beat_sat + CNT_W'(w_sat_re[i]) + CNT_W'(w_sat_im[i]);
        end
    end

    // Stage 2 output registers and the block saturation accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_re    <= {(LANES*OUT_W){1'b0}};
            r_out_im    <= {(LANES*OUT_W){1'b0}};
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_sat_cnt   <= {CNT_W{1'b0}};
            r_sat_acc   <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_out_re    <= {(LANES*OUT_W){1'b0}};
            r_out_im    <= {(LANES*OUT_W){1'b0}};
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_sat_cnt   <= {CNT_W{1'b0}};
            r_sat_acc   <= {CNT_W{1'b0}};
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_re  <= w_y_re;
                r_out_im  <= w_y_im;
                r_out_sop <= r_s1_sop;
                r_out_eop <= r_s1_eop;
                if (r_s1_eop) begin
                    r_sat_cnt <= r_sat_acc + w_beat_sat;
                    r_sat_acc <= {CNT_W{1'b0}};
                end else begin
                    r_sat_cnt <= {CNT_W{1'b0}};
                    r_sat_acc <= r_sat_acc + w_beat_sat;
                end
            end else begin
                r_out_re  <= {(LANES*OUT_W){1'b0}};
                r_out_im  <= {(LANES*OUT_W){1'b0}};
                r_out_sop <= 1'b0;
                r_out_eop <= 1'b0;
                r_sat_cnt <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_cbfp_norm_stream_param.sv
// Self-checking bench for cbfp_norm_stream_param with the default parameters.
// A scoreboard holds the expected output beats. Each expected beat is
// computed with plain integer arithmetic when its input beat is accepted.
module tb_cbfp_norm_stream_param;

    localparam int LANES = 16;
    localparam int IN_W  = 16;
    localparam int OUT_W = 13;
    localparam int IDX_W = 5;
    localparam int BEATS = 32;
    localparam int CNT_W = 11;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_re, in_im;
    logic [LANES*IDX_W-1:0] idx1_re, idx1_im, idx2_re, idx2_im;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_re, out_im;
    logic                   out_sop, out_eop;
    logic [CNT_W-1:0]       sat_cnt;

    typedef struct {
        logic [LANES*OUT_W-1:0] re;
        logic [LANES*OUT_W-1:0] im;
        logic                   sop;
        logic                   eop;
        logic [CNT_W-1:0]       sat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_beat = 0;
    int   m_acc = 0;
    bit   prev_stall = 0;
    logic [LANES*OUT_W-1:0] prev_re, prev_im;
    logic [CNT_W+1:0]       prev_ctl;
    int   n_out, n_sop, first_out, last_out, first_acc;
    bit   first_sop;
    logic [LANES*OUT_W-1:0] cap_sop_re, cap_sop_im, cap_eop_re;
    logic [CNT_W-1:0]       cap_sop_sat, cap_eop_sat;

    cbfp_norm_stream_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_re     (in_re),
        .i_in_im     (in_im),
        .i_idx1_re   (idx1_re),
        .i_idx1_im   (idx1_im),
        .i_idx2_re   (idx2_re),
        .i_idx2_im   (idx2_im),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_re    (out_re),
        .o_out_im    (out_im),
        .o_out_sop   (out_sop),
        .o_out_eop   (out_eop),
        .o_sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] o13(input int v);
        return OUT_W'(v);
    endfunction

    function automatic logic [OUT_W-1:0] lane(input logic [LANES*OUT_W-1:0] v, input int l);
        return v[l*OUT_W +: OUT_W];
    endfunction

    // Reference: scale by 2^(23-sum), round half up, clip to 13-bit signed.
    function automatic int ref_norm(input int x, input int sum, output int sat);
        int sh, s;
        longint d, num, v;
        sh  = 23 - sum;
        sat = 0;
        if (sh > 0) begin
            s   = (sh > IN_W) ? IN_W : sh;
            d   = longint'(1) << s;
            num = longint'(x) + d / 2;
            if (num >= 0) v = num / d;
            else          v = -((-num + d - 1) / d);
        end else if (sh == 0) begin
            v = x;
        end else begin
            s = (-sh > OUT_W) ? OUT_W : -sh;
            v = longint'(x) * (longint'(1) << s);
        end
        if (v > 4095) begin
            v = 4095; sat = 1;
        end else if (v < -4096) begin
            v = -4096; sat = 1;
        end
        return int'(v);
    endfunction

    task automatic set_comp(input int part, input int l, input int x, input int a, input int b);
        if (part == 0) begin
            in_re[l*IN_W +: IN_W]     = IN_W'(x);
            idx1_re[l*IDX_W +: IDX_W] = IDX_W'(a);
            idx2_re[l*IDX_W +: IDX_W] = IDX_W'(b);
        end else begin
            in_im[l*IN_W +: IN_W]     = IN_W'(x);
            idx1_im[l*IDX_W +: IDX_W] = IDX_W'(a);
            idx2_im[l*IDX_W +: IDX_W] = IDX_W'(b);
        end
    endtask

    // mode 0: random beat; mode 1: directed beat k of the known-answer block.
    task automatic gen_beat(input int mode, input int k);
        int x;
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < LANES; l++) begin
                if (mode == 0) begin
                    x = ($urandom_range(0, 1) == 1) ? int'($signed(16'($urandom)))
                                                    : int'($urandom_range(0, 600)) - 300;
                    set_comp(p, l, x, int'($urandom_range(6, 17)), int'($urandom_range(6, 17)));
                end else begin
                    set_comp(p, l, 0, 11, 12);
                end
            end
        end
        if (mode == 1 && k == 0) begin
            set_comp(0, 0, 1000, 11, 12);
            set_comp(1, 0, 1000, 10, 10);
            set_comp(0, 1, -5, 11, 11);
            set_comp(1, 1, 1000, 12, 13);
            set_comp(0, 2, 2000, 12, 13);
            set_comp(1, 2, -2000, 12, 13);
        end
        if (mode == 1 && k == BEATS - 1) begin
            set_comp(0, 3, 2000, 12, 13);
        end
    endtask

    task automatic trk_reset();
        n_out = 0; n_sop = 0; first_out = -1; last_out = -1; first_acc = -1; first_sop = 0;
    endtask

    // Called once per cycle, after inputs are set and before the next rising edge.
    task automatic sample();
        exp_t e, m;
        int y, s, ns;
        cyc++;
        if (!rst_n || flush) begin
            q.delete(); m_beat = 0; m_acc = 0; prev_stall = 0;
            return;
        end
        if (prev_stall) begin
            chk("stable_re", 256'(out_re), 256'(prev_re));
            chk("stable_im", 256'(out_im), 256'(prev_im));
            chk("stable_ctl", 256'({out_sop, out_eop, sat_cnt}), 256'(prev_ctl));
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (first_out < 0) begin first_out = cyc; first_sop = out_sop; end
            last_out = cyc;
            if (out_sop) begin
                n_sop++; cap_sop_re = out_re; cap_sop_im = out_im; cap_sop_sat = sat_cnt;
            end
            if (out_eop) begin cap_eop_re = out_re; cap_eop_sat = sat_cnt; end
            if (q.size() == 0) begin
                chk("spurious_out", 256'(out_valid), 256'(0));
            end else begin
                e = q.pop_front();
                chk("out_re", 256'(out_re), 256'(e.re));
                chk("out_im", 256'(out_im), 256'(e.im));
                chk("out_sop", 256'(out_sop), 256'(e.sop));
                chk("out_eop", 256'(out_eop), 256'(e.eop));
                chk("sat_cnt", 256'(sat_cnt), 256'(e.sat));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_re = out_re; prev_im = out_im; prev_ctl = {out_sop, out_eop, sat_cnt};
        if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            ns = 0;
            for (int l = 0; l < LANES; l++) begin
                y = ref_norm(int'($signed(in_re[l*IN_W +: IN_W])),
                             int'(idx1_re[l*IDX_W +: IDX_W]) + int'(idx2_re[l*IDX_W +: IDX_W]), s);
                m.re[l*OUT_W +: OUT_W] = OUT_W'(y); ns += s;
                y = ref_norm(int'($signed(in_im[l*IN_W +: IN_W])),
                             int'(idx1_im[l*IDX_W +: IDX_W]) + int'(idx2_im[l*IDX_W +: IDX_W]), s);
                m.im[l*OUT_W +: OUT_W] = OUT_W'(y); ns += s;
            end
            m.sop = (m_beat == 0);
            m.eop = (m_beat == BEATS - 1);
            m_acc += ns;
            m.sat = m.eop ? CNT_W'(m_acc) : '0;
            if (m.eop) m_acc = 0;
            m_beat = (m_beat + 1) % BEATS;
            q.push_back(m);
        end
    endtask

    // Offer n beats (pv% valid, pr% ready); optionally drain the pipeline.
    task automatic run_beats(input int n, input int mode, input int pv, input int pr, input bit drain);
        int sent = 0;
        int guard = 0;
        while ((sent < n || (drain && q.size() > 0)) && guard < 5000) begin
            in_valid = (sent < n) && ($urandom_range(0, 99) < pv);
            if (in_valid) gen_beat(mode, sent);
            out_ready = ($urandom_range(0, 99) < pr);
            #1;
            sample();
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) chk("timeout", 256'(guard), 256'(0));
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0; idx1_re = '0; idx1_im = '0; idx2_re = '0; idx2_im = '0;
        trk_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_re", 256'(out_re), 256'(0));
        chk("rst_out_im", 256'(out_im), 256'(0));
        chk("rst_sop_eop", 256'({out_sop, out_eop}), 256'(0));
        chk("rst_sat_cnt", 256'(sat_cnt), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer block: rounding, zero shift, left shift, saturation.
        run_beats(BEATS, 1, 100, 100, 1'b1);
        chk("ka_sum23", 256'(lane(cap_sop_re, 0)), 256'(o13(1000)));
        chk("ka_sum20", 256'(lane(cap_sop_im, 0)), 256'(o13(125)));
        chk("ka_round_neg", 256'(lane(cap_sop_re, 1)), 256'(o13(-2)));
        chk("ka_sum25", 256'(lane(cap_sop_im, 1)), 256'(o13(4000)));
        chk("ka_sat_pos", 256'(lane(cap_sop_re, 2)), 256'(o13(4095)));
        chk("ka_sat_neg", 256'(lane(cap_sop_im, 2)), 256'(o13(-4096)));
        chk("ka_sop_satcnt", 256'(cap_sop_sat), 256'(0));
        chk("ka_eop_lane3", 256'(lane(cap_eop_re, 3)), 256'(o13(4095)));
        chk("ka_eop_satcnt", 256'(cap_eop_sat), 256'(3));

        // Back-to-back stream: two blocks with no bubbles, 2-cycle latency.
        trk_reset();
        run_beats(2 * BEATS, 0, 100, 100, 1'b1);
        chk("b2b_count", 256'(n_out), 256'(2 * BEATS));
        chk("b2b_span", 256'(last_out - first_out + 1), 256'(2 * BEATS));
        chk("b2b_sops", 256'(n_sop), 256'(2));
        chk("b2b_latency", 256'(first_out - first_acc), 256'(2));

        // Random valid and ready over three blocks.
        run_beats(3 * BEATS, 0, 75, 50, 1'b1);

        // Flush after beat 10, while a beat is offered in the same cycle.
        run_beats(10, 0, 100, 100, 1'b0);
        in_valid = 1'b1; gen_beat(0, 0); out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("fl_busy", 256'(out_valid), 256'(1));
        sample();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", 256'(out_valid), 256'(0));
        chk("fl_in_ready", 256'(in_ready), 256'(1));
        chk("fl_out_re", 256'(out_re), 256'(0));
        chk("fl_ctl", 256'({out_sop, out_eop, sat_cnt}), 256'(0));
        sample();
        @(negedge clk);
        trk_reset();
        run_beats(BEATS, 0, 90, 70, 1'b1);
        chk("fl_first_sop", 256'(first_sop), 256'(1));

        // Asynchronous reset mid-block with a stalled valid output.
        run_beats(2, 0, 100, 0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("rs_busy", 256'(out_valid), 256'(1));
        sample();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", 256'(out_valid), 256'(0));
        chk("rs_in_ready", 256'(in_ready), 256'(1));
        chk("rs_out_data", 256'(out_re | out_im), 256'(0));
        chk("rs_ctl", 256'({out_sop, out_eop, sat_cnt}), 256'(0));
        sample();
        @(negedge clk);
        rst_n = 1'b1;
        trk_reset();
        run_beats(BEATS, 0, 80, 60, 1'b1);
        chk("rs_first_sop", 256'(first_sop), 256'(1));
        chk("rs_count", 256'(n_out), 256'(BEATS));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
